// File: rtl/core_pipe_exec_opr_if.sv
// Decode/forwarding/execute signal bundle for the decode-to-execute stage register.
// The master side is decode plus the forwarding sources plus the execute consumer;
// the slave side is the stage register itself.
interface core_pipe_exec_opr_if #(
    parameter int XLEN = 64,
    parameter int OPW  = 10
);
    // Decode side
    logic            s_valid;
    logic            s_ready;
    logic [4:0]      s_rs1;
    logic [4:0]      s_rs2;
    logic [XLEN-1:0] s_rs1_data;
    logic [XLEN-1:0] s_rs2_data;
    logic [XLEN-1:0] s_pc;
    logic [XLEN-1:0] s_imm;
    logic            s_a_pc;
    logic            s_b_imm;
    logic            s_word;
    logic [OPW-1:0]  s_op;

    // Forwarding buses: f0 is the newest result (memory), f1 the older one (writeback)
    logic            f0_valid;
    logic [4:0]      f0_rd;
    logic [XLEN-1:0] f0_data;
    logic            f1_valid;
    logic [4:0]      f1_rd;
    logic [XLEN-1:0] f1_data;

    // Execute side
    logic            e_valid;
    logic            e_ready;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
    logic            e_word;
    logic [OPW-1:0]  e_op;

    modport master (
        output s_valid, s_rs1, s_rs2, s_rs1_data, s_rs2_data, s_pc, s_imm,
               s_a_pc, s_b_imm, s_word, s_op,
               f0_valid, f0_rd, f0_data, f1_valid, f1_rd, f1_data, e_ready,
        input  s_ready, e_valid, opr_a, opr_b, e_word, e_op
    );

    modport slave (
        input  s_valid, s_rs1, s_rs2, s_rs1_data, s_rs2_data, s_pc, s_imm,
               s_a_pc, s_b_imm, s_word, s_op,
               f0_valid, f0_rd, f0_data, f1_valid, f1_rd, f1_data, e_ready,
        output s_ready, e_valid, opr_a, opr_b, e_word, e_op
    );
endinterface

// File: rtl/core_pipe_exec_opr.sv
// Decode-to-execute stage register. Captures one decoded instruction per handshake,
// resolves operands from register file / forwarding / PC / immediate, and keeps
// held register operands fresh from the forwarding buses while execute stalls.
module core_pipe_exec_opr #(
    parameter int XLEN = 64,
    parameter int OPW  = 10
) (
    input  logic                 g_clk,
    input  logic                 g_rst,
    input  logic                 flush,
    core_pipe_exec_opr_if.slave  bus
);

    logic            e_valid_reg;
    logic [XLEN-1:0] opr_a_reg;
    logic [XLEN-1:0] opr_b_reg;
    logic            e_word_reg;
    logic [OPW-1:0]  e_op_reg;
    // Held source register numbers, index 0 = rs1/operand A, 1 = rs2/operand B
    logic [1:0][4:0] held_rs_reg;
    // Operand is register-sourced (eligible for forwarding refresh)
    logic [1:0]      reg_src_reg;

    logic [1:0][XLEN-1:0] resolved_in;
    logic [1:0]           refresh_hit;
    logic [1:0][XLEN-1:0] refresh_val;

    logic accept;
    logic consume;

    // Ready ignores flush on purpose: a flushed handshake simply gets dropped.
    assign bus.s_ready = !e_valid_reg || bus.e_ready;
    assign accept      = bus.s_valid && bus.s_ready && !flush;
    assign consume     = e_valid_reg && bus.e_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [4:0]      rs_in;
            logic [XLEN-1:0] rf_in;
            logic [XLEN-1:0] val_in;
            logic            hit_held;
            logic [XLEN-1:0] val_held;

            assign rs_in = (gi == 0) ? bus.s_rs1 : bus.s_rs2;
            assign rf_in = (gi == 0) ? bus.s_rs1_data : bus.s_rs2_data;

            // Incoming operand: x0 reads zero, then newest forward, older forward, regfile
            always_comb begin
                val_in = rf_in;
                if (rs_in == 5'd0) begin
                    val_in = '0;
                end else if (bus.f0_valid && (bus.f0_rd == rs_in)) begin
                    val_in = bus.f0_data;
                end else if (bus.f1_valid && (bus.f1_rd == rs_in)) begin
                    val_in = bus.f1_data;
                end
            end

            // Held operand refresh: same priority; x0 never refreshes
            always_comb begin
                hit_held = 1'b0;
                val_held = bus.f1_data;
                if (held_rs_reg[gi] != 5'd0) begin
                    if (bus.f0_valid && (bus.f0_rd == held_rs_reg[gi])) begin
                        hit_held = 1'b1;
                        val_held = bus.f0_data;
                    end else if (bus.f1_valid && (bus.f1_rd == held_rs_reg[gi])) begin
                        hit_held = 1'b1;
                        val_held = bus.f1_data;
                    end
                end
            end

            assign resolved_in[gi] = val_in;
            assign refresh_hit[gi] = hit_held && reg_src_reg[gi];
            assign refresh_val[gi] = val_held;
        end
    endgenerate

    // Stage register: reset > flush > accept > consume > hold-with-refresh
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            e_valid_reg <= 1'b0;
            opr_a_reg   <= '0;
            opr_b_reg   <= '0;
            e_word_reg  <= 1'b0;
            e_op_reg    <= '0;
            held_rs_reg <= '0;
            reg_src_reg <= '0;
        end else if (flush) begin
            e_valid_reg <= 1'b0;
            e_op_reg    <= '0;
        end else if (accept) begin
            e_valid_reg <= 1'b1;
            opr_a_reg   <= bus.s_a_pc  ? bus.s_pc  : resolved_in[0];
            opr_b_reg   <= bus.s_b_imm ? bus.s_imm : resolved_in[1];
            e_word_reg  <= bus.s_word;
            e_op_reg    <= bus.s_op;
            held_rs_reg <= {bus.s_rs2, bus.s_rs1};
            reg_src_reg <= {!bus.s_b_imm, !bus.s_a_pc};
        end else if (consume) begin
            // Operands intentionally keep their last values after consume
            e_valid_reg <= 1'b0;
            e_op_reg    <= '0;
        end else if (e_valid_reg) begin
            if (refresh_hit[0]) begin
                opr_a_reg <= refresh_val[0];
            end
            if (refresh_hit[1]) begin
                opr_b_reg <= refresh_val[1];
            end
        end
    end

    assign bus.e_valid = e_valid_reg;
    assign bus.opr_a   = opr_a_reg;
    assign bus.opr_b   = opr_b_reg;
    assign bus.e_word  = e_word_reg;
    assign bus.e_op    = e_op_reg;

endmodule

// File: tb/tb_core_pipe_exec_opr.sv
// Bench for the decode-to-execute stage register: directed scenarios with constant
// expectations, then randomized traffic against an entry-level behavioural model.
module tb_core_pipe_exec_opr;

    localparam int XLEN = 64;
    localparam int OPW  = 10;
    localparam logic [OPW-1:0] OP_ADD = 10'b10_0000_0000;
    localparam logic [OPW-1:0] OP_SUB = 10'b01_0000_0000;

    logic g_clk;
    logic g_rst;
    logic flush;

    int n_cmp = 0;
    int n_err = 0;

    core_pipe_exec_opr_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

    core_pipe_exec_opr #(.XLEN(XLEN), .OPW(OPW)) dut (
        .g_clk (g_clk),
        .g_rst (g_rst),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Reference entry: what execute should be seeing
    typedef struct {
        logic            v;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            w;
        logic [OPW-1:0]  op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            apc;
        logic            bimm;
    } ent_t;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle();
        flush          = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_rs1      = '0;
        bus.s_rs2      = '0;
        bus.s_rs1_data = '0;
        bus.s_rs2_data = '0;
        bus.s_pc       = '0;
        bus.s_imm      = '0;
        bus.s_a_pc     = 1'b0;
        bus.s_b_imm    = 1'b0;
        bus.s_word     = 1'b0;
        bus.s_op       = '0;
        bus.f0_valid   = 1'b0;
        bus.f0_rd      = '0;
        bus.f0_data    = '0;
        bus.f1_valid   = 1'b0;
        bus.f1_rd      = '0;
        bus.f1_data    = '0;
        bus.e_ready    = 1'b1;
    endtask

    task automatic put(input logic [4:0] rs1, input logic [XLEN-1:0] d1,
                       input logic [4:0] rs2, input logic [XLEN-1:0] d2,
                       input logic [OPW-1:0] op);
        bus.s_valid    = 1'b1;
        bus.s_rs1      = rs1;
        bus.s_rs1_data = d1;
        bus.s_rs2      = rs2;
        bus.s_rs2_data = d2;
        bus.s_op       = op;
    endtask

    task automatic test_reset();
        idle();
        g_rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.e_valid !== 1'b0) begin n_err++; $display("FAIL reset_e_valid got=%b want=0", bus.e_valid); end
        n_cmp++; if (bus.opr_a !== 64'd0) begin n_err++; $display("FAIL reset_opr_a got=%h want=0", bus.opr_a); end
        n_cmp++; if (bus.opr_b !== 64'd0) begin n_err++; $display("FAIL reset_opr_b got=%h want=0", bus.opr_b); end
        n_cmp++; if (bus.e_word !== 1'b0) begin n_err++; $display("FAIL reset_e_word got=%b want=0", bus.e_word); end
        n_cmp++; if (bus.e_op !== '0) begin n_err++; $display("FAIL reset_e_op got=%h want=0", bus.e_op); end
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got=%b want=1", bus.s_ready); end
        g_rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic_add();
        idle();
        put(5'd5, 64'h10, 5'd6, 64'h20, OP_ADD);
        bus.s_word = 1'b1;
        tick();
        idle();
        n_cmp++; if (bus.e_valid !== 1'b1) begin n_err++; $display("FAIL add_e_valid got=%b want=1", bus.e_valid); end
        n_cmp++; if (bus.opr_a !== 64'h10) begin n_err++; $display("FAIL add_opr_a got=%h want=10", bus.opr_a); end
        n_cmp++; if (bus.opr_b !== 64'h20) begin n_err++; $display("FAIL add_opr_b got=%h want=20", bus.opr_b); end
        n_cmp++; if (bus.e_op !== OP_ADD) begin n_err++; $display("FAIL add_e_op got=%h want=%h", bus.e_op, OP_ADD); end
        n_cmp++; if (bus.e_word !== 1'b1) begin n_err++; $display("FAIL add_e_word got=%b want=1", bus.e_word); end
        tick();
        n_cmp++; if (bus.e_valid !== 1'b0) begin n_err++; $display("FAIL consume_e_valid got=%b want=0", bus.e_valid); end
        n_cmp++; if (bus.e_op !== '0) begin n_err++; $display("FAIL consume_e_op got=%h want=0", bus.e_op); end
        n_cmp++; if (bus.opr_a !== 64'h10) begin n_err++; $display("FAIL consume_keep_a got=%h want=10", bus.opr_a); end
        $display("txn add a=%h b=%h", 64'h10, 64'h20);
    endtask

    task automatic test_forward_priority();
        idle();
        put(5'd5, 64'h1, 5'd6, 64'h20, OP_ADD);
        bus.f0_valid = 1'b1; bus.f0_rd = 5'd5; bus.f0_data = 64'hAA;
        bus.f1_valid = 1'b1; bus.f1_rd = 5'd5; bus.f1_data = 64'hBB;
        tick();
        idle();
        n_cmp++; if (bus.opr_a !== 64'hAA) begin n_err++; $display("FAIL fwd_f0_prio got=%h want=aa", bus.opr_a); end
        n_cmp++; if (bus.opr_b !== 64'h20) begin n_err++; $display("FAIL fwd_nomatch_b got=%h want=20", bus.opr_b); end
        put(5'd0, 64'h55, 5'd7, 64'h3, OP_SUB);
        bus.f0_valid = 1'b1; bus.f0_rd = 5'd0; bus.f0_data = 64'h99;
        bus.f1_valid = 1'b1; bus.f1_rd = 5'd7; bus.f1_data = 64'hCC;
        tick();
        idle();
        n_cmp++; if (bus.opr_a !== 64'h0) begin n_err++; $display("FAIL fwd_x0 got=%h want=0", bus.opr_a); end
        n_cmp++; if (bus.opr_b !== 64'hCC) begin n_err++; $display("FAIL fwd_f1 got=%h want=cc", bus.opr_b); end
        tick();
        $display("txn forward checks done");
    endtask

    task automatic test_hold_refresh();
        idle();
        put(5'd5, 64'h1, 5'd6, 64'h20, OP_ADD);
        bus.e_ready = 1'b0;
        tick();
        idle();
        bus.e_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL hold_s_ready got=%b want=0", bus.s_ready); end
        n_cmp++; if (bus.opr_b !== 64'h20) begin n_err++; $display("FAIL hold_stable_b got=%h want=20", bus.opr_b); end
        bus.f1_valid = 1'b1; bus.f1_rd = 5'd6; bus.f1_data = 64'h77;
        tick();
        bus.f1_valid = 1'b0;
        n_cmp++; if (bus.opr_b !== 64'h77) begin n_err++; $display("FAIL hold_refresh_b got=%h want=77", bus.opr_b); end
        n_cmp++; if (bus.e_valid !== 1'b1) begin n_err++; $display("FAIL hold_e_valid got=%b want=1", bus.e_valid); end
        bus.f0_valid = 1'b1; bus.f0_rd = 5'd5; bus.f0_data = 64'h44;
        bus.f1_valid = 1'b1; bus.f1_rd = 5'd5; bus.f1_data = 64'h66;
        tick();
        bus.f0_valid = 1'b0; bus.f1_valid = 1'b0;
        tick();
        n_cmp++; if (bus.opr_a !== 64'h44) begin n_err++; $display("FAIL hold_refresh_prio got=%h want=44", bus.opr_a); end
        n_cmp++; if (bus.opr_b !== 64'h77) begin n_err++; $display("FAIL hold_keep_b got=%h want=77", bus.opr_b); end
        bus.e_ready = 1'b1;
        tick();
        $display("txn hold refresh a=%h b=%h", 64'h44, 64'h77);
    endtask

    task automatic test_hold_imm();
        idle();
        put(5'd5, 64'h1, 5'd6, 64'h20, OP_ADD);
        bus.s_a_pc = 1'b1; bus.s_pc = 64'h1000;
        bus.s_b_imm = 1'b1; bus.s_imm = 64'h3;
        bus.e_ready = 1'b0;
        tick();
        idle();
        bus.e_ready = 1'b0;
        tick();
        tick();
        bus.f1_valid = 1'b1; bus.f1_rd = 5'd6; bus.f1_data = 64'h77;
        bus.f0_valid = 1'b1; bus.f0_rd = 5'd5; bus.f0_data = 64'h88;
        tick();
        tick();
        n_cmp++; if (bus.opr_b !== 64'h3) begin n_err++; $display("FAIL imm_no_refresh got=%h want=3", bus.opr_b); end
        n_cmp++; if (bus.opr_a !== 64'h1000) begin n_err++; $display("FAIL pc_no_refresh got=%h want=1000", bus.opr_a); end
        idle();
        tick();
        $display("txn hold imm a=%h b=%h", 64'h1000, 64'h3);
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 4; i++) begin
            put(5'(i + 1), 64'(i * 256 + 1), 5'(i + 10), 64'(i * 256 + 2), (i % 2 == 0) ? OP_ADD : OP_SUB);
            #1;
            n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_s_ready[%0d] got=%b want=1", i, bus.s_ready); end
            tick();
            n_cmp++; if (bus.e_valid !== 1'b1) begin n_err++; $display("FAIL b2b_e_valid[%0d] got=%b want=1", i, bus.e_valid); end
            n_cmp++; if (bus.opr_a !== 64'(i * 256 + 1)) begin n_err++; $display("FAIL b2b_opr_a[%0d] got=%h want=%h", i, bus.opr_a, 64'(i * 256 + 1)); end
            n_cmp++; if (bus.opr_b !== 64'(i * 256 + 2)) begin n_err++; $display("FAIL b2b_opr_b[%0d] got=%h want=%h", i, bus.opr_b, 64'(i * 256 + 2)); end
            $display("txn b2b %0d a=%h b=%h", i, bus.opr_a, bus.opr_b);
        end
        idle();
        tick();
        n_cmp++; if (bus.e_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b want=0", bus.e_valid); end
    endtask

    task automatic test_flush();
        idle();
        put(5'd3, 64'h33, 5'd4, 64'h44, OP_ADD);
        bus.e_ready = 1'b0;
        tick();
        put(5'd8, 64'h80, 5'd9, 64'h90, OP_SUB);
        flush = 1'b1;
        tick();
        n_cmp++; if (bus.e_valid !== 1'b0) begin n_err++; $display("FAIL flush_hold_e_valid got=%b want=0", bus.e_valid); end
        n_cmp++; if (bus.e_op !== '0) begin n_err++; $display("FAIL flush_hold_e_op got=%h want=0", bus.e_op); end
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL flush_s_ready got=%b want=1", bus.s_ready); end
        tick();
        n_cmp++; if (bus.e_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got=%b want=0", bus.e_valid); end
        flush = 1'b0;
        bus.e_ready = 1'b1;
        tick();
        n_cmp++; if (bus.e_valid !== 1'b1) begin n_err++; $display("FAIL post_flush_valid got=%b want=1", bus.e_valid); end
        n_cmp++; if (bus.opr_a !== 64'h80) begin n_err++; $display("FAIL post_flush_a got=%h want=80", bus.opr_a); end
        n_cmp++; if (bus.e_op !== OP_SUB) begin n_err++; $display("FAIL post_flush_op got=%h want=%h", bus.e_op, OP_SUB); end
        idle();
        tick();
        $display("txn flush then accept a=%h", 64'h80);
    endtask

    task automatic test_reset_mid_hold();
        idle();
        put(5'd2, 64'h22, 5'd3, 64'h33, OP_ADD);
        bus.s_word = 1'b1;
        bus.e_ready = 1'b0;
        tick();
        tick();
        g_rst = 1'b1;
        tick();
        n_cmp++; if (bus.e_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid got=%b want=0", bus.e_valid); end
        n_cmp++; if (bus.opr_a !== 64'd0) begin n_err++; $display("FAIL rst_hold_a got=%h want=0", bus.opr_a); end
        n_cmp++; if (bus.opr_b !== 64'd0) begin n_err++; $display("FAIL rst_hold_b got=%h want=0", bus.opr_b); end
        n_cmp++; if (bus.e_op !== '0) begin n_err++; $display("FAIL rst_hold_op got=%h want=0", bus.e_op); end
        n_cmp++; if (bus.e_word !== 1'b0) begin n_err++; $display("FAIL rst_hold_word got=%b want=0", bus.e_word); end
        g_rst = 1'b0;
        idle();
        tick();
        $display("txn reset mid hold");
    endtask

    // Spec operand rule; `fallback` is regfile data on accept or the held value on refresh
    function automatic logic [XLEN-1:0] pick(input logic [4:0] rs, input logic [XLEN-1:0] fallback);
        if (rs == 5'd0) return '0;
        if (bus.f0_valid && bus.f0_rd == rs) return bus.f0_data;
        if (bus.f1_valid && bus.f1_rd == rs) return bus.f1_data;
        return fallback;
    endfunction

    task automatic test_random();
        ent_t m, n;
        int   ntxn;
        idle();
        g_rst = 1'b1;
        tick();
        g_rst = 1'b0;
        m = '{v: 1'b0, a: '0, b: '0, w: 1'b0, op: '0, rs1: '0, rs2: '0, apc: 1'b0, bimm: 1'b0};
        ntxn = 0;
        for (int c = 0; c < 600; c++) begin
            flush          = ($urandom_range(0, 7) == 0);
            bus.s_valid    = ($urandom_range(0, 3) != 0);
            bus.e_ready    = $urandom_range(0, 1) == 1;
            bus.s_rs1      = 5'($urandom_range(0, 7));
            bus.s_rs2      = 5'($urandom_range(0, 7));
            bus.s_rs1_data = {$urandom, $urandom};
            bus.s_rs2_data = {$urandom, $urandom};
            bus.s_pc       = {$urandom, $urandom};
            bus.s_imm      = {$urandom, $urandom};
            bus.s_a_pc     = ($urandom_range(0, 3) == 0);
            bus.s_b_imm    = ($urandom_range(0, 3) == 0);
            bus.s_word     = $urandom_range(0, 1) == 1;
            bus.s_op       = OPW'(1) << $urandom_range(0, OPW - 1);
            bus.f0_valid   = $urandom_range(0, 1) == 1;
            bus.f0_rd      = 5'($urandom_range(0, 7));
            bus.f0_data    = {$urandom, $urandom};
            bus.f1_valid   = $urandom_range(0, 1) == 1;
            bus.f1_rd      = 5'($urandom_range(0, 7));
            bus.f1_data    = {$urandom, $urandom};
            #1;
            n_cmp++; if (bus.s_ready !== (!m.v || bus.e_ready)) begin n_err++; $display("FAIL rnd_s_ready c=%0d got=%b want=%b", c, bus.s_ready, !m.v || bus.e_ready); end
            n = m;
            if (flush) begin
                n.v = 1'b0; n.op = '0;
            end else if (bus.s_valid && (!m.v || bus.e_ready)) begin
                n.v    = 1'b1;
                n.a    = bus.s_a_pc  ? bus.s_pc  : pick(bus.s_rs1, bus.s_rs1_data);
                n.b    = bus.s_b_imm ? bus.s_imm : pick(bus.s_rs2, bus.s_rs2_data);
                n.w    = bus.s_word;
                n.op   = bus.s_op;
                n.rs1  = bus.s_rs1;
                n.rs2  = bus.s_rs2;
                n.apc  = bus.s_a_pc;
                n.bimm = bus.s_b_imm;
                ntxn++;
                $display("txn rnd %0d a=%h b=%h op=%h", ntxn, n.a, n.b, n.op);
            end else if (m.v && bus.e_ready) begin
                n.v = 1'b0; n.op = '0;
            end else if (m.v) begin
                if (!m.apc)  n.a = pick(m.rs1, m.a);
                if (!m.bimm) n.b = pick(m.rs2, m.b);
            end
            tick();
            m = n;
            n_cmp++; if (bus.e_valid !== m.v) begin n_err++; $display("FAIL rnd_e_valid c=%0d got=%b want=%b", c, bus.e_valid, m.v); end
            n_cmp++; if (bus.e_op !== m.op) begin n_err++; $display("FAIL rnd_e_op c=%0d got=%h want=%h", c, bus.e_op, m.op); end
            if (m.v) begin
                n_cmp++; if (bus.opr_a !== m.a) begin n_err++; $display("FAIL rnd_opr_a c=%0d got=%h want=%h", c, bus.opr_a, m.a); end
                n_cmp++; if (bus.opr_b !== m.b) begin n_err++; $display("FAIL rnd_opr_b c=%0d got=%h want=%h", c, bus.opr_b, m.b); end
                n_cmp++; if (bus.e_word !== m.w) begin n_err++; $display("FAIL rnd_e_word c=%0d got=%b want=%b", c, bus.e_word, m.w); end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        g_rst = 1'b1;
        idle();
        test_reset();
        test_basic_add();
        test_forward_priority();
        test_hold_refresh();
        test_hold_imm();
        test_back_to_back();
        test_flush();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
